tx_initiated_point_test_tx: RTL
===============================

TX_INITIATED_POINT_TEST_TX -- requirements
Module: tx_initiated_point_test_tx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd8000, meaning wait-state timeout in clk cycles (used only with TX_PT_TIMEOUT_EN).
REQ-002 SHALL have port clk, input, 1, sole clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port i_en, input, 1, test enable; low aborts to IDLE.
REQ-005 SHALL have port i_mainband_or_valtrain_test, input, 1; 0 = mainband, 1 = valtrain.
REQ-006 SHALL have port i_lfsr_or_perlane, input, 1; 0 = LFSR, 1 = per-lane ID.
REQ-007 SHALL have ports i_sideband_message (input, 4), i_sideband_message_valid (input, 1) and i_sideband_data (input, 16), carrying the received partner message.
REQ-008 SHALL have port i_msg_info, input, 1, result-valid flag of the received message.
REQ-009 SHALL have ports i_valid_rx (input, 1), partner-FSM sideband request, and i_busy_negedge_detected (input, 1), sideband send complete.
REQ-010 SHALL have port i_pattern_done, input, 1, pattern generator finished.
REQ-011 SHALL have ports o_sideband_message (output, 4) and o_valid_tx (output, 1), the outgoing request and its send request.
REQ-012 SHALL have ports o_pattern_gen_cw (output, 2; 00 off, 01 clear, 10 LFSR, 11 per-lane) and o_valtrain_en (output, 1).
REQ-013 SHALL have ports o_results (output, 16), o_result_valid (output, 1), o_timeout (output, 1) and o_test_ack_tx (output, 1).

Function
REQ-014 SHALL implement states IDLE, SEND_TEST_REQ, WAIT_TEST_RESP, SEND_CLR_REQ, WAIT_CLR_RESP, PATTERN, SEND_RESULT_REQ, WAIT_RESULT_RESP, SEND_END_REQ, WAIT_END_RESP, TEST_FINISH.
REQ-015 SHALL move IDLE->SEND_TEST_REQ when i_en=1.
REQ-016 SHALL, in SEND_* states, drive o_sideband_message to 0001 (test req), 0011 (LFSR clear req), 0101 (result req) or 0111 (end req) respectively.
REQ-017 SHALL set o_valid_tx=1 on the cycle after entering a SEND_* state if i_valid_rx=0; otherwise it SHALL hold a pending flag and assert o_valid_tx on the first cycle after i_valid_rx is low.
REQ-018 SHALL clear o_valid_tx on i_busy_negedge_detected; the falling edge of o_valid_tx SHALL advance SEND_x to the matching WAIT state.
REQ-019 SHALL leave WAIT states only on i_sideband_message_valid=1 with codes 0010 (->SEND_CLR_REQ), 0100 (->PATTERN), 0110 (->SEND_END_REQ) and 1000 (->TEST_FINISH); other codes and valid messages in non-WAIT states SHALL be ignored.
REQ-020 SHALL, in WAIT_RESULT_RESP on code 0110, register o_results<=i_sideband_data and o_result_valid<=i_msg_info, holding both until IDLE.
REQ-021 SHALL, in PATTERN, drive o_pattern_gen_cw=01 for exactly the first cycle, then 10/11 per i_lfsr_or_perlane for mainband, or o_valtrain_en=1 with cw=00 for valtrain.
REQ-022 SHALL leave PATTERN for SEND_RESULT_REQ on i_pattern_done=1, driving cw=00 and o_valtrain_en=0 from the next cycle; i_pattern_done during the clear cycle SHALL be ignored.
REQ-023 SHALL set o_test_ack_tx=1 in TEST_FINISH and hold it until i_en=0, which returns the FSM to IDLE.
REQ-024 SHALL, from any state with i_en=0, go to IDLE next cycle and clear all outputs, the pending flag and o_valid_tx.
REQ-025 SHALL treat simultaneous i_busy_negedge_detected and a new-send condition as a clear (no re-assert that cycle).

Reset
REQ-026 SHALL, on rst=1, immediately force state IDLE and all outputs, counters and flags to 0, including mid-handshake.

Configuration
REQ-027 SHALL, with macro TX_PT_TIMEOUT_EN defined, count cycles in each WAIT_* state (restarting at entry); reaching TIMEOUT_CYCLES SHALL go to TEST_FINISH with o_timeout=1 and o_test_ack_tx=1.
REQ-028 SHALL, without TX_PT_TIMEOUT_EN, have no counter, tie o_timeout to 0 and let WAIT states wait indefinitely.

Verification
REQ-029 Bench SHALL run a full mainband LFSR pass: i_en=1, partner replies 0010/0100/0110 (data 16'hA5A5, info 1)/1000 -> requests 0001,0011,0101,0111 sent in order; cw 01 then 10; o_results=A5A5, o_result_valid=1, o_test_ack_tx=1.
REQ-030 Bench SHALL run valtrain: i_mainband_or_valtrain_test=1 -> o_valtrain_en=1 until i_pattern_done, then 0; cw remains 00 after the clear cycle.
REQ-031 Bench SHALL test arbitration: i_valid_rx=1 for 5 cycles at SEND_TEST_REQ entry -> o_valid_tx stays 0, rises the cycle after i_valid_rx falls.
REQ-032 Bench SHALL test abort: i_en=0 in PATTERN -> IDLE next cycle, cw=00, o_valid_tx=0.
REQ-033 Bench SHALL test timeout (macro on, TIMEOUT_CYCLES=16): no reply in WAIT_TEST_RESP -> o_timeout=1 and o_test_ack_tx=1 after 16 cycles; macro off -> still waiting at 100 cycles.
REQ-034 Bench SHALL assert rst mid-send -> all outputs 0 asynchronously, FSM restarts from IDLE.

Source files
------------

// File: rtl/tx_initiated_point_test_tx.sv
// ----------------------------------------------------------------------------
// tx_initiated_point_test_tx
//
// Transmitter-side sequencer for a TX-initiated point test. It walks the
// partner through a four-message sideband exchange (test request, LFSR clear,
// result request, end request). Between the clear and result exchanges it runs
// the local pattern generator or the valid-train pattern. The captured partner
// result is then presented.
//
// Optional feature: define TX_PT_TIMEOUT_EN to bound every WAIT_* state to
// TIMEOUT_CYCLES clock cycles. When this macro is undefined, WAIT states wait
// indefinitely and o_timeout is tied low.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   i_en                         test enable; low returns to IDLE and clears all
//   i_mainband_or_valtrain_test  0 = mainband, 1 = valtrain
//   i_lfsr_or_perlane            0 = LFSR, 1 = per-lane ID pattern
//   i_sideband_message[3:0]      received partner message code
//   i_sideband_message_valid     received message strobe
//   i_sideband_data[15:0]        received message payload (partner results)
//   i_msg_info                   result-valid flag carried by the message
//   i_valid_rx                   partner FSM currently owns the sideband
//   i_busy_negedge_detected      our sideband send has completed
//   i_pattern_done               pattern generator finished
//   o_sideband_message[3:0]      outgoing request code (valid in SEND_* states)
//   o_valid_tx                   request to send o_sideband_message
//   o_pattern_gen_cw[1:0]        00 off, 01 clear, 10 LFSR, 11 per-lane
//   o_valtrain_en                valid-train pattern enable
//   o_results[15:0]              partner results
//   o_result_valid               partner result-valid flag
//   o_timeout                    a WAIT state timed out
//   o_test_ack_tx                test finished, held until i_en drops
// ----------------------------------------------------------------------------
module tx_initiated_point_test_tx #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_mainband_or_valtrain_test,
    input  logic        i_lfsr_or_perlane,
    input  logic [3:0]  i_sideband_message,
    input  logic        i_sideband_message_valid,
    input  logic [15:0] i_sideband_data,
    input  logic        i_msg_info,
    input  logic        i_valid_rx,
    input  logic        i_busy_negedge_detected,
    input  logic        i_pattern_done,
    output logic [3:0]  o_sideband_message,
    output logic        o_valid_tx,
    output logic [1:0]  o_pattern_gen_cw,
    output logic        o_valtrain_en,
    output logic [15:0] o_results,
    output logic        o_result_valid,
    output logic        o_timeout,
    output logic        o_test_ack_tx
);

    localparam logic [3:0] IDLE             = 4'd0;
    localparam logic [3:0] SEND_TEST_REQ    = 4'd1;
    localparam logic [3:0] WAIT_TEST_RESP   = 4'd2;
    localparam logic [3:0] SEND_CLR_REQ     = 4'd3;
    localparam logic [3:0] WAIT_CLR_RESP    = 4'd4;
    localparam logic [3:0] PATTERN          = 4'd5;
    localparam logic [3:0] SEND_RESULT_REQ  = 4'd6;
    localparam logic [3:0] WAIT_RESULT_RESP = 4'd7;
    localparam logic [3:0] SEND_END_REQ     = 4'd8;
    localparam logic [3:0] WAIT_END_RESP    = 4'd9;
    localparam logic [3:0] TEST_FINISH      = 4'd10;

    localparam logic [3:0] MSG_TEST_REQ    = 4'b0001;
    localparam logic [3:0] MSG_TEST_RESP   = 4'b0010;
    localparam logic [3:0] MSG_CLR_REQ     = 4'b0011;
    localparam logic [3:0] MSG_CLR_RESP    = 4'b0100;
    localparam logic [3:0] MSG_RESULT_REQ  = 4'b0101;
    localparam logic [3:0] MSG_RESULT_RESP = 4'b0110;
    localparam logic [3:0] MSG_END_REQ     = 4'b0111;
    localparam logic [3:0] MSG_END_RESP    = 4'b1000;

    logic [3:0]  state_reg;
    logic        valid_tx_reg;
    logic        send_pending_reg;   // request queued, waiting for a free sideband
    logic        pattern_first_reg;  // first PATTERN cycle (generator clear)
    logic [1:0]  cw_reg;
    logic        valtrain_en_reg;
    logic [15:0] results_reg;
    logic        result_valid_reg;
    logic        timeout_reg;
    logic        ack_reg;

    // Per-state decode: outgoing code and the WAIT state it leads to for
    // SEND states, and the only response code accepted for WAIT states.
    logic [3:0]  req_msg;
    logic [3:0]  resp_msg;
    logic [3:0]  wait_next;
    logic        is_send;
    logic        is_wait;
    logic        resp_hit;

    always_comb begin
        req_msg   = 4'b0000;
        resp_msg  = 4'b0000;
        wait_next = IDLE;
        is_send   = 1'b0;
        is_wait   = 1'b0;
        case (state_reg)
            SEND_TEST_REQ:    begin req_msg = MSG_TEST_REQ;   wait_next = WAIT_TEST_RESP;   is_send = 1'b1; end
            SEND_CLR_REQ:     begin req_msg = MSG_CLR_REQ;    wait_next = WAIT_CLR_RESP;    is_send = 1'b1; end
            SEND_RESULT_REQ:  begin req_msg = MSG_RESULT_REQ; wait_next = WAIT_RESULT_RESP; is_send = 1'b1; end
            SEND_END_REQ:     begin req_msg = MSG_END_REQ;    wait_next = WAIT_END_RESP;    is_send = 1'b1; end
            WAIT_TEST_RESP:   begin resp_msg = MSG_TEST_RESP;   is_wait = 1'b1; end
            WAIT_CLR_RESP:    begin resp_msg = MSG_CLR_RESP;    is_wait = 1'b1; end
            WAIT_RESULT_RESP: begin resp_msg = MSG_RESULT_RESP; is_wait = 1'b1; end
            WAIT_END_RESP:    begin resp_msg = MSG_END_RESP;    is_wait = 1'b1; end
            default:          ;
        endcase
    end

    assign resp_hit = is_wait && i_sideband_message_valid && (i_sideband_message == resp_msg);

`ifdef TX_PT_TIMEOUT_EN
    logic [15:0] wait_cnt_reg;
`else
    logic unused_timeout_param;
    assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            valid_tx_reg      <= 1'b0;
            send_pending_reg  <= 1'b0;
            pattern_first_reg <= 1'b0;
            cw_reg            <= 2'b00;
            valtrain_en_reg   <= 1'b0;
            results_reg       <= 16'h0000;
            result_valid_reg  <= 1'b0;
            timeout_reg       <= 1'b0;
            ack_reg           <= 1'b0;
`ifdef TX_PT_TIMEOUT_EN
            wait_cnt_reg      <= 16'd0;
`endif
        end else if (!i_en) begin
            state_reg         <= IDLE;
            valid_tx_reg      <= 1'b0;
            send_pending_reg  <= 1'b0;
            pattern_first_reg <= 1'b0;
            cw_reg            <= 2'b00;
            valtrain_en_reg   <= 1'b0;
            results_reg       <= 16'h0000;
            result_valid_reg  <= 1'b0;
            timeout_reg       <= 1'b0;
            ack_reg           <= 1'b0;
`ifdef TX_PT_TIMEOUT_EN
            wait_cnt_reg      <= 16'd0;
`endif
        end else begin
            // Send handshake shared by every SEND_* state. A send-complete
            // pulse wins over a new assertion in the same cycle; the falling
            // edge of o_valid_tx is what moves us on to the WAIT state.
            if (is_send) begin
                if (i_busy_negedge_detected) begin
                    valid_tx_reg <= 1'b0;
                    if (valid_tx_reg) begin
                        state_reg <= wait_next;
                    end
                end else if (send_pending_reg && !i_valid_rx) begin
                    valid_tx_reg     <= 1'b1;
                    send_pending_reg <= 1'b0;
                end
            end

            case (state_reg)
                IDLE: begin
                    state_reg        <= SEND_TEST_REQ;
                    send_pending_reg <= 1'b1;
                end
                WAIT_TEST_RESP: if (resp_hit) begin
                    state_reg        <= SEND_CLR_REQ;
                    send_pending_reg <= 1'b1;
                end
                WAIT_CLR_RESP: if (resp_hit) begin
                    state_reg         <= PATTERN;
                    cw_reg            <= 2'b01;
                    pattern_first_reg <= 1'b1;
                end
                PATTERN: begin
                    if (pattern_first_reg) begin
                        // Clear cycle: i_pattern_done is ignored here.
                        pattern_first_reg <= 1'b0;
                        if (i_mainband_or_valtrain_test) begin
                            cw_reg          <= 2'b00;
                            valtrain_en_reg <= 1'b1;
                        end else begin
                            cw_reg <= {1'b1, i_lfsr_or_perlane};
                        end
                    end else if (i_pattern_done) begin
                        state_reg        <= SEND_RESULT_REQ;
                        send_pending_reg <= 1'b1;
                        cw_reg           <= 2'b00;
                        valtrain_en_reg  <= 1'b0;
                    end
                end
                WAIT_RESULT_RESP: if (resp_hit) begin
                    state_reg        <= SEND_END_REQ;
                    send_pending_reg <= 1'b1;
                    results_reg      <= i_sideband_data;
                    result_valid_reg <= i_msg_info;
                end
                WAIT_END_RESP: if (resp_hit) begin
                    state_reg <= TEST_FINISH;
                    ack_reg   <= 1'b1;
                end
                SEND_TEST_REQ, SEND_CLR_REQ, SEND_RESULT_REQ, SEND_END_REQ, TEST_FINISH: ;
                default: state_reg <= IDLE;
            endcase

`ifdef TX_PT_TIMEOUT_EN
            // Counter restarts on every WAIT entry because it is held at zero
            // outside WAIT states and on the cycle a WAIT state is left.
            if (is_wait && !resp_hit) begin
                if (wait_cnt_reg == TIMEOUT_CYCLES - 16'd1) begin
                    state_reg    <= TEST_FINISH;
                    timeout_reg  <= 1'b1;
                    ack_reg      <= 1'b1;
                    wait_cnt_reg <= 16'd0;
                end else begin
                    wait_cnt_reg <= wait_cnt_reg + 16'd1;
                end
            end else begin
                wait_cnt_reg <= 16'd0;
            end
`endif
        end
    end

    assign o_sideband_message = req_msg;
    assign o_valid_tx         = valid_tx_reg;
    assign o_pattern_gen_cw   = cw_reg;
    assign o_valtrain_en      = valtrain_en_reg;
    assign o_results          = results_reg;
    assign o_result_valid     = result_valid_reg;
    assign o_timeout          = timeout_reg;
    assign o_test_ack_tx      = ack_reg;

endmodule
